// File: rtl/module_register_file_pkg.sv
// Shared constants and read-port request/response types for the register file.
// Optional build macro used by the register file: REGFILE_BYPASS_EN.
package module_register_file_pkg;

  localparam int unsigned REG_ZERO              = 0;
  localparam int unsigned NUM_REGS_DEFAULT      = 32;
  localparam int unsigned REG_ADDR_BITS         = 5;
  localparam int unsigned DATA_WIDTH_DEFAULT    = 32;
  localparam int unsigned ADDRESS_WIDTH_DEFAULT = 32;

  typedef struct packed {
    logic                     en;
    logic [REG_ADDR_BITS-1:0] addr;
  } rd_req_t;

  typedef struct packed {
    logic                          valid;
    logic [DATA_WIDTH_DEFAULT-1:0] data;
  } rd_rsp_t;

endpackage

// File: rtl/module_register_file_if.sv
// Decode-side write bus plus the two execute-side read ports of the register file.
// master = decode/execute side, slave = register file.
interface module_register_file_if
  import module_register_file_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int unsigned REG_ADDR_BITS = module_register_file_pkg::REG_ADDR_BITS
);

  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    data;
  logic                     wr_err;

  logic                     rd_en_a;
  logic [REG_ADDR_BITS-1:0] rd_addr_a;
  logic [DATA_WIDTH-1:0]    rd_data_a;
  logic                     rd_valid_a;

  logic                     rd_en_b;
  logic [REG_ADDR_BITS-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0]    rd_data_b;
  logic                     rd_valid_b;

  modport master (
    output wr_en, addr, data, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  wr_err, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
  );

  modport slave (
    input  wr_en, addr, data, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output wr_err, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
  );

endinterface

// File: rtl/module_regfile_read_port.sv
// One registered read port: index range check, R0/out-of-range zeroing, optional
// same-cycle write forwarding (REGFILE_BYPASS_EN), output data register and valid pulse.
module module_regfile_read_port
  import module_register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int unsigned REG_ADDR_BITS = module_register_file_pkg::REG_ADDR_BITS,
  parameter int unsigned NUM_REGS      = NUM_REGS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [REG_ADDR_BITS-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    regs [NUM_REGS],
`ifdef REGFILE_BYPASS_EN
  input  logic                     fwd_en,
  input  logic [REG_ADDR_BITS-1:0] fwd_addr,
  input  logic [DATA_WIDTH-1:0]    fwd_data,
`endif
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid
);

  logic                  in_range_s;
  logic                  is_zero_s;
  logic [DATA_WIDTH-1:0] stored_s;
  logic [DATA_WIDTH-1:0] next_data_s;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;

  assign in_range_s = ({1'b0, rd_addr} < (REG_ADDR_BITS + 1)'(NUM_REGS));
  assign is_zero_s  = (rd_addr == REG_ADDR_BITS'(REG_ZERO));

  // Stored value lookup; R0 and indices past the last register read as zero.
  always_comb begin
    stored_s = '0;
    if (in_range_s && !is_zero_s) begin
      stored_s = regs[rd_addr];
    end else begin
      stored_s = '0;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // fwd_en is only raised for legal nonzero writes, so no extra R0 check here.
  assign next_data_s = (fwd_en && (fwd_addr == rd_addr)) ? fwd_data : stored_s;
`else
  assign next_data_s = stored_s;
`endif

  // Output data register (holds when idle) and one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= next_data_s;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;

endmodule

// File: rtl/module_register_file.sv
// Architectural register file: storage, write decode and sticky error flag, two read ports.
// Build macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module module_register_file
  import module_register_file_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int unsigned REG_ADDR_BITS = module_register_file_pkg::REG_ADDR_BITS,
  parameter int unsigned NUM_REGS      = NUM_REGS_DEFAULT
) (
  input logic                   clk,
  input logic                   rst,
  module_register_file_if.slave bus
);

  logic [DATA_WIDTH-1:0]    regs_r [NUM_REGS];
  logic                     wr_err_r;
  logic                     wr_in_range_s;
  logic [REG_ADDR_BITS-1:0] wr_idx_s;
  logic                     wr_hit_s;
  logic                     wr_drop_s;

  // Full-width compare so any set bit above the index field counts as out of range.
  assign wr_in_range_s = (bus.addr < ADDRESS_WIDTH'(NUM_REGS));
  assign wr_idx_s      = bus.addr[REG_ADDR_BITS-1:0];
  assign wr_hit_s      = bus.wr_en && wr_in_range_s && (wr_idx_s != REG_ADDR_BITS'(REG_ZERO));
  assign wr_drop_s     = bus.wr_en && !wr_in_range_s;

  // Register storage; R0 is only ever loaded by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_hit_s) begin
      regs_r[wr_idx_s] <= bus.data;
    end
  end

  // Sticky dropped-write flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_r <= 1'b0;
    end else if (wr_drop_s) begin
      wr_err_r <= 1'b1;
    end
  end

  assign bus.wr_err = wr_err_r;

  module_regfile_read_port #(
    .DATA_WIDTH   (DATA_WIDTH),
    .REG_ADDR_BITS(REG_ADDR_BITS),
    .NUM_REGS     (NUM_REGS)
  ) u_port_a (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (bus.rd_en_a),
    .rd_addr (bus.rd_addr_a),
    .regs    (regs_r),
`ifdef REGFILE_BYPASS_EN
    .fwd_en  (wr_hit_s),
    .fwd_addr(wr_idx_s),
    .fwd_data(bus.data),
`endif
    .rd_data (bus.rd_data_a),
    .rd_valid(bus.rd_valid_a)
  );

  module_regfile_read_port #(
    .DATA_WIDTH   (DATA_WIDTH),
    .REG_ADDR_BITS(REG_ADDR_BITS),
    .NUM_REGS     (NUM_REGS)
  ) u_port_b (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (bus.rd_en_b),
    .rd_addr (bus.rd_addr_b),
    .regs    (regs_r),
`ifdef REGFILE_BYPASS_EN
    .fwd_en  (wr_hit_s),
    .fwd_addr(wr_idx_s),
    .fwd_data(bus.data),
`endif
    .rd_data (bus.rd_data_b),
    .rd_valid(bus.rd_valid_b)
  );

endmodule
